// File: rtl/dcache_pkg.sv
// Shared types and byte-lane helpers for the direct-mapped write-through data cache.
// Lanes are big-endian: offset k selects word bits [31-8k -: 8].
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int WORD_W      = 32;
  localparam int LANE_W      = 8;
  localparam int OFFSET_BITS = 2;

  function automatic logic [WORD_W-1:0] lane_select(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        offset);
    logic [LANE_W-1:0] lane;
    case (offset)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
    return {{(WORD_W-LANE_W){1'b0}}, lane};
  endfunction

  function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic [1:0]        offset);
    logic [WORD_W-1:0] merged;
    merged = word;
    case (offset)
      2'd0:    merged[31:24] = lane;
      2'd1:    merged[23:16] = lane;
      2'd2:    merged[15:8]  = lane;
      default: merged[7:0]   = lane;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: async-cleared valid bits, unreset tag/data, one combinational read port
// and one synchronous write port (full word + tag + valid, or a single byte lane).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int CACHE_SIZE = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_word_en,
  input  logic                  wr_lane_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]            wr_offset,
  input  logic [BYTE_WIDTH-1:0] wr_lane
);

  logic [CACHE_SIZE-1:0] valid_q;
  logic [TAG_BITS-1:0]   tag_q  [CACHE_SIZE];
  logic [DATA_WIDTH-1:0] data_q [CACHE_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_word_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // A lane write only ever happens on a hit, so tag and valid are already correct.
  always_ff @(posedge clk) begin
    if (wr_word_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end else if (wr_lane_en) begin
      data_q[wr_index] <= lane_merge(data_q[wr_index], wr_lane, wr_offset);
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate data cache, one word per line.
// Read hits return in the request cycle; misses and all stores stall until mem_ready.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int CACHE_SIZE    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     cpu_byte_op,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte_op,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready
);

  localparam int INDEX_BITS = $clog2(CACHE_SIZE);
  localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;

  state_t                   state;
  logic                     req_we;
  logic                     req_byte_op;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic [ADDRESS_WIDTH-1:0] look_addr;
  logic [INDEX_BITS-1:0]    look_index;
  logic [TAG_BITS-1:0]      look_tag;
  logic                     line_valid;
  logic [TAG_BITS-1:0]      line_tag;
  logic [DATA_WIDTH-1:0]    line_data;
  logic                     hit;
  logic                     idle_start;
  logic                     busy;
  logic                     wr_word_en;
  logic                     wr_lane_en;
  logic [DATA_WIDTH-1:0]    wr_data;

  // While busy the CPU inputs are held, but the captured request is authoritative.
  assign look_addr  = (state == IDLE) ? cpu_addr : req_addr;
  assign look_index = look_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign look_tag   = look_addr[ADDRESS_WIDTH-1:INDEX_BITS+OFFSET_BITS];
  assign hit        = line_valid && (line_tag == look_tag);
  assign idle_start = (state == IDLE) && cpu_req && (cpu_we || !hit);
  assign busy       = (state == FILL) || (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_we      <= 1'b0;
      req_byte_op <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_start) begin
            req_we      <= cpu_we;
            req_byte_op <= cpu_byte_op;
            req_addr    <= cpu_addr;
            req_wdata   <= cpu_wdata;
            state       <= cpu_we ? WRITE : FILL;
          end
        end
        FILL, WRITE: begin
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_word_en = mem_ready && ((state == FILL) ||
                                    ((state == WRITE) && hit && !req_byte_op));
  assign wr_lane_en = mem_ready && (state == WRITE) && hit && req_byte_op;
  assign wr_data    = (state == FILL) ? mem_rdata : req_wdata;

  dcache_array #(
    .CACHE_SIZE (CACHE_SIZE),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (look_index),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .wr_word_en (wr_word_en),
    .wr_lane_en (wr_lane_en),
    .wr_index   (look_index),
    .wr_tag     (look_tag),
    .wr_data    (wr_data),
    .wr_offset  (req_addr[1:0]),
    .wr_lane    (req_wdata[BYTE_WIDTH-1:0])
  );

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte_op = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      WRITE: begin
        mem_req     = 1'b1;
        mem_we      = req_we;
        mem_byte_op = req_byte_op;
        mem_addr    = req_addr;
        mem_wdata   = req_wdata;
      end
      default: ;
    endcase
  end

  // CPU-facing outputs are forced quiet while reset is held, even with cpu_req high.
  assign cpu_stall = rst_n && (idle_start || (busy && !mem_ready));

  always_comb begin
    cpu_rdata = '0;
    if (rst_n) begin
      if ((state == IDLE) && cpu_req && !cpu_we && hit) begin
        cpu_rdata = cpu_byte_op ? lane_select(line_data, cpu_addr[1:0]) : line_data;
      end else if ((state == FILL) && mem_ready) begin
        cpu_rdata = req_byte_op ? lane_select(mem_rdata, req_addr[1:0]) : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench: the driver pushes expected memory cycles and load data into queues,
// a negedge monitor pops and compares whenever the cache presents them.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct packed {
    logic        we;
    logic        bop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [31:0] rd_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_byte_op (cpu_byte_op),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_byte_op (mem_byte_op),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_mem(input logic we, input logic bop, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask, input int n);
    mem_exp_t e;
    e.we = we; e.bop = bop; e.addr = addr; e.wdata = wdata; e.mask = mask;
    for (int i = 0; i < n; i++) mem_q.push_back(e);
  endtask

  // slow = number of FILL cycles with mem_ready held low.
  task automatic access(input logic we, input logic bop, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int slow, input int exp_stalls, input logic [31:0] exp_rd);
    int stalls;
    int fill_wait;
    stalls = 0;
    fill_wait = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_byte_op = bop; cpu_addr = addr; cpu_wdata = wdata;
    mem_rdata = rdata; mem_ready = (slow == 0);
    if (!we) rd_q.push_back(exp_rd);
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (mem_req) fill_wait++;
      if (stalls > 100) begin
        check("stall_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      mem_ready = (fill_wait >= slow);
    end
    check($sformatf("stall_cycles@%08h", addr), stalls, exp_stalls);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_op = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", 1, 0);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_cycle", {mem_we, mem_byte_op, mem_addr, mem_wdata & e.mask},
                {e.we, e.bop, e.addr, e.wdata & e.mask});
        end
      end
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (rd_q.size() == 0) check("rdata_unexpected", 1, 0);
        else check("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end else if (!cpu_req) begin
        check("idle_outputs", {cpu_stall, cpu_rdata}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_op = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ready = 1'b1;
    #1;
    check("reset_outputs",
          {mem_req, mem_we, mem_byte_op, mem_addr, mem_wdata, cpu_stall, cpu_rdata}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill, hit, byte hit
    push_mem(0, 0, 32'h0001_0000, 0, 0, 1);
    access(0, 0, 32'h0001_0000, 0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
    access(0, 0, 32'h0001_0000, 0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    access(0, 1, 32'h0001_0002, 0, 32'h0, 0, 0, 32'h0000_00BE);

    // Byte store hit updates only lane 1
    push_mem(1, 1, 32'h0001_0001, 32'h0000_0055, 32'h0000_00FF, 1);
    access(1, 1, 32'h0001_0001, 32'hAAAA_AA55, 0, 0, 1, 0);
    access(0, 0, 32'h0001_0000, 0, 32'h0, 0, 0, 32'hDE55_BEEF);

    // Conflict eviction on index 0
    push_mem(0, 0, 32'h0001_0100, 0, 0, 1);
    access(0, 0, 32'h0001_0100, 0, 32'h1234_5678, 0, 1, 32'h1234_5678);
    push_mem(0, 0, 32'h0001_0000, 0, 0, 1);
    access(0, 0, 32'h0001_0000, 0, 32'hDE55_BEEF, 0, 1, 32'hDE55_BEEF);

    // Slow memory, byte load of lane 3 with aligned fill address
    push_mem(0, 0, 32'h0001_0004, 0, 0, 4);
    access(0, 1, 32'h0001_0007, 0, 32'h0BAD_F00D, 3, 4, 32'h0000_000D);
    access(0, 0, 32'h0001_0004, 0, 32'h0, 0, 0, 32'h0BAD_F00D);

    // Write miss does not allocate
    push_mem(1, 0, 32'h0002_0000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1);
    access(1, 0, 32'h0002_0000, 32'hCAFE_F00D, 0, 0, 1, 0);
    push_mem(0, 0, 32'h0002_0000, 0, 0, 1);
    access(0, 0, 32'h0002_0000, 0, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);

    // Word store hit replaces the cached word
    push_mem(1, 0, 32'h0001_0004, 32'h1122_3344, 32'hFFFF_FFFF, 1);
    access(1, 0, 32'h0001_0004, 32'h1122_3344, 0, 0, 1, 0);
    access(0, 0, 32'h0001_0004, 0, 32'h0, 0, 0, 32'h1122_3344);

    // Reset in the middle of a fill
    push_mem(0, 0, 32'h0003_0008, 0, 0, 1);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte_op = 1'b0; cpu_addr = 32'h0003_0008; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("in_fill_before_reset", {mem_req, cpu_stall}, 2'b11);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_fill", {mem_req, cpu_stall}, 0);
    cpu_req = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_mem(0, 0, 32'h0001_0004, 0, 0, 1);
    access(0, 0, 32'h0001_0004, 0, 32'h1122_3344, 0, 1, 32'h1122_3344);

    repeat (2) @(posedge clk);
    check("mem_queue_drained", mem_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
